// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: latches EXE results, extends load data, feeds WB and ID forwarding.
module mem_stage #(
    parameter int EXE_TO_MEM_W = 76,
    parameter int MEM_TO_WB_W  = 70,
    parameter int MEM_TO_ID_W  = 38
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [EXE_TO_MEM_W-1:0] exe_to_mem_bus,
    input  logic                    exe_to_mem_valid,
    output logic                    mem_allow_in,
    output logic [MEM_TO_WB_W-1:0]  mem_to_wb_bus,
    output logic                    mem_to_wb_valid,
    input  logic                    wb_allow_in,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_ID_W-1:0]  mem_to_id_bus,
    output logic                    mem_valid
);

    logic                    mem_ready_go;
    logic [EXE_TO_MEM_W-1:0] mem_reg;
    logic                    rdata_held;
    logic [31:0]             rdata_buf;
    logic [31:0]             rdata;

    logic [4:0]  ld_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] mem_result;
    logic [31:0] final_result;
    logic        enter;
    logic        drain;

    assign {ld_op, res_from_mem, gr_we, dest, alu_result, pc} = mem_reg;

    assign mem_ready_go    = 1'b1;
    assign mem_allow_in    = !mem_valid || (mem_ready_go && wb_allow_in);
    assign mem_to_wb_valid = mem_valid && mem_ready_go;
    assign enter           = mem_allow_in && exe_to_mem_valid;
    assign drain           = mem_to_wb_valid && wb_allow_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
        end else if (mem_allow_in) begin
            mem_valid <= exe_to_mem_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_reg <= '0;
        end else if (enter) begin
            mem_reg <= exe_to_mem_bus;
        end
    end

    // SRAM data is only presented in the first MEM cycle, so capture it if WB stalls us.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_held <= 1'b0;
            rdata_buf  <= '0;
        end else if (enter || drain) begin
            rdata_held <= 1'b0;
        end else if (mem_valid && !rdata_held && !wb_allow_in) begin
            rdata_held <= 1'b1;
            rdata_buf  <= data_sram_rdata;
        end
    end

    assign rdata = rdata_held ? rdata_buf : data_sram_rdata;

    always_comb begin
        ld_byte = rdata[7:0];
        case (alu_result[1:0])
            2'd0: ld_byte = rdata[7:0];
            2'd1: ld_byte = rdata[15:8];
            2'd2: ld_byte = rdata[23:16];
            2'd3: ld_byte = rdata[31:24];
            default: ld_byte = rdata[7:0];
        endcase
        ld_half = alu_result[1] ? rdata[31:16] : rdata[15:0];
    end

    // ld_op bit order is {ld_b, ld_h, ld_w, ld_bu, ld_hu}; ld_w and no-op both pass the word.
    always_comb begin
        mem_result = rdata;
        if (ld_op[4]) begin
            mem_result = {{24{ld_byte[7]}}, ld_byte};
        end else if (ld_op[3]) begin
            mem_result = {{16{ld_half[15]}}, ld_half};
        end else if (ld_op[1]) begin
            mem_result = {24'd0, ld_byte};
        end else if (ld_op[0]) begin
            mem_result = {16'd0, ld_half};
        end
    end

    assign final_result  = res_from_mem ? mem_result : alu_result;
    assign mem_to_wb_bus = {gr_we, dest, final_result, pc};
    assign mem_to_id_bus = {mem_valid && gr_we && (dest != 5'd0), dest, final_result};

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage LoongArch pipeline, between EXE and WB.
- Latches the EXE result bundle and sign/zero-extends load data returned by the synchronous data SRAM, which receives its request in EXE.
- Emits the 70-bit bundle consumed by WB, plus a valid-gated forwarding bundle to ID for hazard handling.
- Uses the same valid / allow_in / ready_go handshake as the other stages.

Parameters:
EXE_TO_MEM_W, 76, width of exe_to_mem_bus {ld_op[4:0], res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}
MEM_TO_WB_W, 70, width of mem_to_wb_bus {gr_we, dest[4:0], final_result[31:0], pc[31:0]}
MEM_TO_ID_W, 38, width of mem_to_id_bus {fwd_we, fwd_dest[4:0], fwd_data[31:0]}

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
exe_to_mem_bus  in  EXE_TO_MEM_W  EXE result bundle
exe_to_mem_valid  in  1  EXE holds a valid instruction for MEM
mem_allow_in  out  1  MEM can accept this cycle
mem_to_wb_bus  out  MEM_TO_WB_W  bundle to WB
mem_to_wb_valid  out  1  bundle to WB is valid
wb_allow_in  in  1  WB can accept
data_sram_rdata  in  32  SRAM read data, valid in the first cycle after the EXE request
mem_to_id_bus  out  MEM_TO_ID_W  forwarding bundle to ID
mem_valid  out  1  MEM holds a valid instruction (hazard detection)

Behaviour:
- Handshake:
  - mem_ready_go = 1.
  - mem_allow_in = !mem_valid || (mem_ready_go && wb_allow_in).
  - mem_to_wb_valid = mem_valid && mem_ready_go.
- mem_valid register:
  - reset -> 0.
  - else if mem_allow_in -> mem_valid <= exe_to_mem_valid.
  - else hold.
- Pipeline register mem_reg:
  - loads exe_to_mem_bus only when mem_allow_in && exe_to_mem_valid.
  - otherwise holds; reset clears it to 0.
  - It must not latch unconditionally.
- Read-data hold:
  - data_sram_rdata is valid only in the first cycle an instruction occupies MEM.
  - Flag rdata_held and 32-bit rdata_buf.
  - When mem_valid && !rdata_held && !(wb_allow_in): rdata_buf <= data_sram_rdata, rdata_held <= 1.
  - rdata_held clears when a new instruction enters (mem_allow_in && exe_to_mem_valid), when the stage drains, and on reset.
  - Effective rdata = rdata_held ? rdata_buf : data_sram_rdata.
- Load extraction, selected by alu_result[1:0]; ld_op is one-hot {ld_b, ld_h, ld_w, ld_bu, ld_hu}:
  - byte = rdata[8*a+7 : 8*a], where a = alu_result[1:0].
  - half = alu_result[1] ? rdata[31:16] : rdata[15:0]; alu_result[0] is ignored for halves.
  - ld_w uses the full word; alu_result[1:0] is ignored.
  - ld_b / ld_h sign-extend; ld_bu / ld_hu zero-extend.
  - ld_op all-zero with res_from_mem = 1 -> mem_result = rdata.
- final_result = res_from_mem ? mem_result : alu_result.
- mem_to_wb_bus = {gr_we, dest, final_result, pc}. It is combinational from mem_reg and is driven even when invalid; WB gates it with the valid signal.
- mem_to_id_bus:
  - fwd_we = mem_valid && gr_we && (dest != 0).
  - fwd_dest = dest.
  - fwd_data = final_result.
- Reset values: mem_valid = 0, mem_to_wb_valid = 0, mem_allow_in = 1, mem_to_id_bus = 0, mem_to_wb_bus = 0.
- Stall (wb_allow_in = 0 while mem_valid):
  - mem_reg holds and outputs are stable.
  - mem_allow_in = 0, so EXE holds.
- Simultaneous drain and fill (mem_valid, wb_allow_in = 1, exe_to_mem_valid = 1): the new instruction replaces the old one in the same edge; no bubble.
- Reset mid-stall: mem_valid, rdata_held and mem_reg clear on the next edge regardless of wb_allow_in.
- Latency: 1 cycle, from the EXE handshake to mem_to_wb_valid.

Test Plan:
- Reset asserted 2 cycles -> mem_valid = 0, mem_allow_in = 1, mem_to_id_bus = 0; after release with no input, mem_to_wb_valid stays 0.
- ld_b, alu_result = 0x1003, rdata = 0x80FF_7F01 -> final_result = 0xFFFF_FF80. Same with ld_bu -> 0x0000_0080.
- ld_h, alu_result = 0x1002, rdata = 0x8001_1234 -> 0xFFFF_8001. ld_hu at 0x1000 with the same data -> 0x0000_1234.
- Non-load add, gr_we = 1, dest = 5, alu_result = 0xDEAD_BEEF:
  - -> mem_to_id_bus = {1, 5, 0xDEAD_BEEF} while valid.
  - With dest = 0 -> fwd_we = 0.
- ld_w issued, wb_allow_in = 0 for 3 cycles, data_sram_rdata changes to garbage after cycle 1:
  - -> final_result stays at the first-cycle word and mem_allow_in = 0 throughout.
  - On release, exactly one mem_to_wb_valid handoff occurs.
- Back-to-back valid instructions A and B with wb_allow_in = 1 -> WB sees A then B on consecutive cycles with no bubble. Asserting reset while B is in MEM -> mem_valid = 0 the next cycle.
